// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {IDLE, LOCK} rr_state_t;

  typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 data multiplexer.
module mux_4_1 #(
  parameter int W = 4
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_pick_4.sv
// Rotating-priority encoder: returns the first asserted request at or after ptr.
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         ptr,
  output req_idx_t         idx,
  output logic             any
);

  // Walk from farthest to nearest so the request closest to ptr wins.
  always_comb begin
    idx = ptr;
    any = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[req_idx_t'(ptr + req_idx_t'(k))]) idx = req_idx_t'(ptr + req_idx_t'(k));
    end
  end

endmodule

// File: rtl/rr_mux_4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four valid/ready/last streams,
// with packet locking and a single registered output stage.
module rr_mux_4_arbiter
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [N_REQ*W-1:0] in_data,
  input  logic [N_REQ-1:0]   in_last,
  output logic [N_REQ-1:0]   in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [1:0]         out_src,
  output logic               out_last,
  input  logic               out_ready
);

  rr_state_t   state;
  req_idx_t    owner;
  req_idx_t    ptr;
  req_idx_t    pick_idx;
  logic        pick_any;
  req_idx_t    grant;
  logic        grant_vld;
  logic        en;
  logic        xfer;
  logic        sel_last;
  logic [W-1:0] sel_data;

  rr_pick_4 u_pick (
    .req (in_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  mux_4_1 #(.W(W)) u_mux (
    .sel (grant),
    .d0  (in_data[0*W +: W]),
    .d1  (in_data[1*W +: W]),
    .d2  (in_data[2*W +: W]),
    .d3  (in_data[3*W +: W]),
    .y   (sel_data)
  );

  assign en        = !out_valid || out_ready;
  assign grant     = (state == LOCK) ? owner : pick_idx;
  assign grant_vld = (state == LOCK) ? in_valid[owner] : pick_any;
  assign sel_last  = in_last[grant];
  assign xfer      = |(in_valid & in_ready);

  // Ready is held low during reset so nothing is accepted before the arbiter is live.
  always_comb begin
    in_ready = '0;
    if (rst && en && grant_vld) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (xfer) begin
        if (state == IDLE && !sel_last) begin
          state <= LOCK;
          owner <= grant;
        end else if (state == LOCK && sel_last) begin
          state <= IDLE;
        end
        // Priority only rotates at packet boundaries.
        if (sel_last) ptr <= grant + 2'd1;
      end
      if (en) begin
        out_valid <= xfer;
        out_data  <= sel_data;
        out_src   <= grant;
        out_last  <= sel_last;
      end
    end
  end

endmodule

// File: doc/rr_mux_4_arbiter.md
Name: rr_mux_4_arbiter

Overview:
- Shares one 4:1 data multiplexer between four requesters, each with a valid/ready/last stream.
- Sequences the mux select with round-robin arbitration and locks the grant for multi-beat packets until the beat carrying `last` is accepted.
- Drives a single registered output stream to a downstream consumer.

Parameters:
- W, default 4, data width of every input and of the output.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data  input  4*W  requester i data at bits [i*W +: W].
- in_last  input  4  per-requester end-of-packet marker.
- in_ready  output  4  per-requester ready; at most one bit is high in any cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  selected data.
- out_src  output  2  index of the requester that produced the beat.
- out_last  output  1  copy of in_last for the beat.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, out_src=0, out_last=0, state=IDLE, priority pointer=0 (requester 0 highest). in_ready=0 while rst=0.
- Handshake rules:
  - A beat transfers when in_valid[i] and in_ready[i] are both high.
  - Output transfers when out_valid and out_ready are both high.
  - A requester must hold in_valid, in_data and in_last stable until its beat transfers.
- Pipe enable: en = !out_valid || out_ready.
- Grant:
  - IDLE: grant is the first i with in_valid[i]=1, searching ptr, ptr+1, ... mod 4. grant_vld = |in_valid.
  - LOCK: grant = owner register. Other requesters are ignored even if valid.
- in_ready[i] = en && grant_vld && (grant==i). This is combinational from in_valid, state and out_ready; there is no combinational path from in_data.
- State machine:
  - IDLE to LOCK when a beat transfers with in_last=0; owner is set to grant.
  - IDLE stays IDLE when a beat transfers with in_last=1 (single-beat packet).
  - LOCK to IDLE when the owner's beat transfers with in_last=1.
  - LOCK stays LOCK when the owner's beat transfers with in_last=0, or when no transfer occurs (owner idle with in_valid=0 gaps is legal).
- Pointer: when a beat with in_last=1 transfers from requester g, ptr <= (g+1) mod 4, wrapping 3 to 0. The pointer does not change otherwise.
- Output register:
  - When en=1: out_valid <= (input transfer this cycle); out_data, out_src and out_last <= the granted requester's values.
  - When en=0: the register holds.
  - Latency: 1 cycle from input transfer to out_valid.
  - Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready are 0, and grant and state are frozen.
- Simultaneous events: an output drain and a new input load in the same cycle are legal and give back-to-back beats.
- No requests: out_valid falls to 0 after the last drain; state and pointer are unchanged.
- Reset mid-packet: LOCK is abandoned, and any beat in the output register is dropped (out_valid=0).

Decomposition:
- Shared package rr_arb_pkg holds:
  - typedef enum logic {IDLE, LOCK} rr_state_t;
  - localparam N_REQ=4;
  - typedef logic [1:0] req_idx_t.
- One sub-module, rr_pick_4: a combinational rotating-priority encoder with inputs req[3:0] and ptr[1:0], and outputs idx[1:0] and any.
- The data select reuses the existing 4:1 mux (mux_4_1) for W=4, with sel=grant.

Test Plan:
- Reset with all in_valid=1: all outputs 0 during reset. On the first cycle after release, in_ready=4'b0001. In the following cycle, out_src=0 and out_valid=1.
- Requesters 0–3 all valid with single-beat packets (in_last=1), data 4'hA/B/C/D, out_ready=1: out_src sequence 0,1,2,3,0 on consecutive cycles, with out_data A,B,C,D,A.
- Requester 1 sends a 3-beat packet (last on the 3rd beat) while requester 2 is valid: out_src=1,1,1 then 2. in_ready[2] stays 0 until the 3rd beat transfers.
- Owner gap: requester 1 is in LOCK and drops in_valid for 2 cycles while requester 0 is valid: no beat from 0 is granted, and the packet completes from 1 afterward.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and data 4'h5: out_data stays 4'h5 and in_ready=0. The beat drains on the cycle out_ready=1, and the next beat loads in the same cycle.
- Pointer wrap: only requester 3 sends a single beat, then requesters 0 and 3 are both valid: requester 0 is granted first.
